// File: rtl/forward_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: the pipe entry record and
// helpers for sizing the forward-select field.
package forward_scoreboard_pkg;

  localparam int REG_W = 5;
  localparam int IDX_W = 4;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } entry_t;

  function automatic int sel_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/forward_scoreboard_match.sv
// Compares one source register against the tracked pipe and reports the
// youngest matching producer and whether its result is usable in time.
module scoreboard_match
  import forward_scoreboard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int MIN_STAGE  = 1,
  parameter int LOOKAHEAD  = 0,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3
) (
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  entry_t [DEPTH:1] entries,
  output logic [IDX_W-1:0] idx,
  output logic             hit,
  output logic             ready
);

  logic hit_load;
  int   need;

  // Scan oldest to youngest so the smallest matching stage wins.
  always_comb begin
    idx      = '0;
    hit      = 1'b0;
    hit_load = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (k >= MIN_STAGE && used && src != '0 &&
          entries[k].valid && entries[k].rd == src) begin
        idx      = IDX_W'(k);
        hit      = 1'b1;
        hit_load = entries[k].is_load;
      end
    end
  end

  // LOOKAHEAD accounts for the producer advancing before the consumer reads;
  // the last stage is always usable through register-file write-through.
  always_comb begin
    need  = hit_load ? LOAD_READY : ALU_READY;
    ready = !hit || (int'(idx) + LOOKAHEAD >= need) || (int'(idx) == DEPTH);
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Tracks in-flight register writers behind ID, stalls consumers whose
// producer is not ready yet, and selects forwarding sources for EX.
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   id_valid,
  input  logic [NUM_SRC*REG_W-1:0]               id_src,
  input  logic [NUM_SRC-1:0]                     id_src_used,
  input  logic [REG_W-1:0]                       id_rd,
  input  logic                                   id_regwrite,
  input  logic                                   id_is_load,
  input  logic                                   ex_flush,
  output logic                                   stall,
  output logic [NUM_SRC*sel_width(DEPTH)-1:0]    fwd_sel,
  output logic                                   hazard_err,
  output logic [15:0]                            stall_count
);

  localparam int SELW = sel_width(DEPTH);

  entry_t [DEPTH:1]          pipe;
  logic [NUM_SRC*REG_W-1:0]  ex_src;
  logic [NUM_SRC-1:0]        ex_used;
  logic [NUM_SRC-1:0]        id_hazard;
  logic [NUM_SRC-1:0]        ex_error;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    logic [IDX_W-1:0] id_idx, ex_idx;
    logic             id_hit, id_ready, ex_hit, ex_ready;

    scoreboard_match #(
      .DEPTH(DEPTH), .MIN_STAGE(1), .LOOKAHEAD(1),
      .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY)
    ) u_id_match (
      .src(id_src[i*REG_W +: REG_W]),
      .used(id_valid & id_src_used[i]),
      .entries(pipe),
      .idx(id_idx),
      .hit(id_hit),
      .ready(id_ready)
    );

    // Stage 1 holds the EX instruction itself, so EX looks from stage 2 on.
    scoreboard_match #(
      .DEPTH(DEPTH), .MIN_STAGE(2), .LOOKAHEAD(0),
      .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY)
    ) u_ex_match (
      .src(ex_src[i*REG_W +: REG_W]),
      .used(ex_used[i]),
      .entries(pipe),
      .idx(ex_idx),
      .hit(ex_hit),
      .ready(ex_ready)
    );

    assign id_hazard[i]              = id_hit & ~id_ready & (id_idx != '0);
    assign fwd_sel[i*SELW +: SELW]   = ex_hit ? SELW'(ex_idx - 1'b1) : '0;
    assign ex_error[i]               = ex_hit & ~ex_ready;
  end

  assign stall      = |id_hazard;
  assign hazard_err = |ex_error;

  // A stall or a flush turns the slot entering EX into a bubble; the rest
  // of the pipe keeps draining either way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe        <= '0;
      ex_src      <= '0;
      ex_used     <= '0;
      stall_count <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        pipe[k] <= pipe[k-1];
      end
      if (stall || ex_flush) begin
        pipe[1] <= '0;
        ex_src  <= '0;
        ex_used <= '0;
      end else begin
        pipe[1].valid   <= id_valid & id_regwrite & (id_rd != '0);
        pipe[1].rd      <= id_rd;
        pipe[1].is_load <= id_is_load;
        ex_src          <= id_src;
        ex_used         <= id_src_used & {NUM_SRC{id_valid}};
      end
      if (stall && stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench: directed vector tables on the default and a deeper
// configuration, a reset-during-stall sequence, and a long random run.
module tb_forward_scoreboard;

  typedef struct {
    logic        valid;
    logic [4:0]  s0, s1;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic        rw, ld, fl;
    logic        stall;
    logic [2:0]  f0, f1;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          dut;
    logic        stall;
    logic [2:0]  f0, f1;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  id_rd;
  logic        id_regwrite, id_is_load, ex_flush;

  logic        stall3, err3, stall5, err5;
  logic [3:0]  fwd3;
  logic [5:0]  fwd5;
  logic [15:0] cnt3, cnt5;

  int compared   = 0;
  int mismatched = 0;

  vec_t tbl[$];
  vec_t tbl5[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  forward_scoreboard dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .ex_flush(ex_flush), .stall(stall3),
    .fwd_sel(fwd3), .hazard_err(err3), .stall_count(cnt3)
  );

  forward_scoreboard #(.DEPTH(5), .LOAD_READY(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .ex_flush(ex_flush), .stall(stall5),
    .fwd_sel(fwd5), .hazard_err(err5), .stall_count(cnt5)
  );

  function automatic vec_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                              input logic [1:0] u, input logic [4:0] rd, input logic rw,
                              input logic ld, input logic fl, input logic st,
                              input logic [2:0] f0, input logic [2:0] f1, input logic [15:0] c);
    vec_t r;
    r.valid = v; r.s0 = s0; r.s1 = s1; r.used = u; r.rd = rd; r.rw = rw;
    r.ld = ld; r.fl = fl; r.stall = st; r.f0 = f0; r.f1 = f1; r.cnt = c;
    return r;
  endfunction

  function automatic vec_t idle(input logic [2:0] f0, input logic [2:0] f1, input logic [15:0] c);
    return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, f0, f1, c);
  endfunction

  task automatic pushExp(input int dut, input logic st, input logic [2:0] f0,
                         input logic [2:0] f1, input logic [15:0] c);
    exp_t e;
    e.dut = dut; e.stall = st; e.f0 = f0; e.f1 = f1; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v, input int dut);
    id_valid    = v.valid;
    id_src      = {v.s1, v.s0};
    id_src_used = v.used;
    id_rd       = v.rd;
    id_regwrite = v.rw;
    id_is_load  = v.ld;
    ex_flush    = v.fl;
    pushExp(dut, v.stall, v.f0, v.f1, v.cnt);
  endtask

  task automatic checkOne(input string name, input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t        e;
    logic        s, er;
    logic [2:0]  a0, a1;
    logic [15:0] c;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    if (e.dut == 0) begin
      s = stall3; a0 = {1'b0, fwd3[1:0]}; a1 = {1'b0, fwd3[3:2]}; er = err3; c = cnt3;
    end else begin
      s = stall5; a0 = fwd5[2:0]; a1 = fwd5[5:3]; er = err5; c = cnt5;
    end
    checkOne({tag, " stall"},       {15'd0, s},  {15'd0, e.stall});
    checkOne({tag, " fwd_sel0"},    {13'd0, a0}, {13'd0, e.f0});
    checkOne({tag, " fwd_sel1"},    {13'd0, a1}, {13'd0, e.f1});
    checkOne({tag, " stall_count"}, c,           e.cnt);
    checkOne({tag, " hazard_err"},  {15'd0, er}, 16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   issued, cycles, ns3, ns5;
    logic hold;

    // Default config: ALU forward, load-use stall, youngest match, r0,
    // flush, unused sources, second-slot stall, then a stall left pending.
    tbl.push_back(mk(1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 4, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 2, 2'b11, 8, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 5, 2, 2'b11, 8, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(idle(2, 0, 1));
    tbl.push_back(mk(1, 1, 2, 2'b11, 4, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 2, 2'b11, 4, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4, 4, 2'b11, 9, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(idle(1, 1, 1));
    tbl.push_back(mk(1, 1, 0, 2'b01, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 2'b11, 10, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 2'b01, 7, 1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 7, 0, 2'b01, 11, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 2'b01, 13, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 13, 13, 2'b00, 12, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 2'b01, 14, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 2, 14, 2'b11, 16, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 2, 14, 2'b11, 16, 1, 0, 0, 0, 0, 0, 2));
    tbl.push_back(idle(0, 2, 2));
    tbl.push_back(mk(1, 1, 0, 2'b01, 15, 1, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 15, 15, 2'b11, 17, 1, 0, 0, 1, 0, 0, 2));

    // Deeper config: load ready in stage 4 costs two stall cycles.
    tbl5.push_back(mk(1, 1, 0, 2'b01, 2, 1, 1, 0, 0, 0, 0, 0));
    tbl5.push_back(mk(1, 2, 0, 2'b01, 18, 1, 0, 0, 1, 0, 0, 0));
    tbl5.push_back(mk(1, 2, 0, 2'b01, 18, 1, 0, 0, 1, 0, 0, 1));
    tbl5.push_back(mk(1, 2, 0, 2'b01, 18, 1, 0, 0, 0, 0, 0, 2));
    tbl5.push_back(idle(3, 0, 2));

    rst_n = 1'b0;
    applyStimulus(idle(0, 0, 0), 0);
    void'(sb.pop_front());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    pushExp(0, 0, 0, 0, 0);
    checkOutput("reset3");
    pushExp(1, 0, 0, 0, 0);
    checkOutput("reset5");

    foreach (tbl[i]) begin
      @(negedge clk);
      applyStimulus(tbl[i], 0);
      #2;
      checkOutput($sformatf("v%0d", i));
    end

    // Reset while the last consumer is still stalled, ID held unchanged.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    pushExp(0, 0, 0, 0, 0);
    checkOutput("midstall reset");

    foreach (tbl5[i]) begin
      @(negedge clk);
      applyStimulus(tbl5[i], 1);
      #2;
      checkOutput($sformatf("d5v%0d", i));
    end

    // Random instruction stream; ID is held while either design stalls.
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(idle(0, 0, 0), 0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n  = 1'b1;
    hold   = 1'b0;
    issued = 0;
    cycles = 0;
    ns3    = 0;
    ns5    = 0;
    while (issued < 10000 && cycles < 40000) begin
      if (!hold) begin
        id_valid    = ($urandom_range(0, 7) != 0);
        id_src      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        id_src_used = 2'($urandom_range(0, 3));
        id_rd       = 5'($urandom_range(0, 7));
        id_regwrite = ($urandom_range(0, 3) != 0);
        id_is_load  = ($urandom_range(0, 2) == 0);
        issued++;
      end
      ex_flush = ($urandom_range(0, 15) == 0);
      #2;
      checkOne("rand hazard_err3", {15'd0, err3}, 16'd0);
      checkOne("rand hazard_err5", {15'd0, err5}, 16'd0);
      if (stall3) ns3++;
      if (stall5) ns5++;
      hold = stall3 | stall5;
      cycles++;
      @(negedge clk);
    end
    checkOne("rand cycle budget", {15'd0, issued >= 10000}, 16'd1);
    checkOne("rand stall_count3", cnt3, 16'(ns3));
    checkOne("rand stall_count5", cnt5, 16'(ns5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
